// File: rtl/exp_power_unit.sv
// Sequential a^n unit using right-to-left square-and-multiply, one exponent bit per cycle.
// Define EXP_OVF_EN to add overflow tracking with saturation; otherwise results wrap.
module exp_power_unit #(
    parameter int W_A   = 8,
    parameter int W_N   = 8,
    parameter int W_OUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go_i,
    input  logic [W_A-1:0]   a_i,
    input  logic [W_N-1:0]   n_i,
    output logic [W_OUT-1:0] output_reg,
    output logic             sig_done,
    output logic             busy_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

`ifdef EXP_OVF_EN
    // Products are kept double-width so the upper half exposes overflow.
    localparam int PW = 2 * W_OUT;
`else
    localparam int PW = W_OUT;
`endif

    state_t           state_q, state_d;
    logic [W_OUT-1:0] acc_q, acc_d;
    logic [W_OUT-1:0] base_q, base_d;
    logic [W_OUT-1:0] result_q, result_d;
    logic [W_N-1:0]   exp_q, exp_d;
    logic [PW-1:0]    accProd;
    logic [PW-1:0]    baseProd;

    assign accProd  = PW'(acc_q) * PW'(base_q);
    assign baseProd = PW'(base_q) * PW'(base_q);

`ifdef EXP_OVF_EN
    logic ovfAcc_q, ovfAcc_d;
    logic ovf_q, ovf_d;
    logic accOvf;
    logic sqOvf;

    // A square that overflows only matters if a later exponent bit would consume it.
    assign accOvf = exp_q[0] && (|accProd[PW-1:W_OUT]);
    assign sqOvf  = ((exp_q >> 1) != '0) && (|baseProd[PW-1:W_OUT]);
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        exp_d    = exp_q;
        result_d = result_q;
`ifdef EXP_OVF_EN
        ovfAcc_d = ovfAcc_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (go_i) begin
                    base_d  = W_OUT'(a_i);
                    exp_d   = n_i;
                    acc_d   = W_OUT'(1);
`ifdef EXP_OVF_EN
                    ovfAcc_d = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                if (exp_q != '0) begin
                    if (exp_q[0]) begin
                        acc_d = accProd[W_OUT-1:0];
                    end
                    base_d = baseProd[W_OUT-1:0];
                    exp_d  = exp_q >> 1;
`ifdef EXP_OVF_EN
                    if (accOvf || sqOvf) begin
                        ovfAcc_d = 1'b1;
                    end
`endif
                end else begin
                    state_d = DONE;
`ifdef EXP_OVF_EN
                    result_d = ovfAcc_q ? '1 : acc_q;
                    ovf_d    = ovfAcc_q;
`else
                    result_d = acc_q;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            result_q <= '0;
`ifdef EXP_OVF_EN
            ovfAcc_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            result_q <= result_d;
`ifdef EXP_OVF_EN
            ovfAcc_q <= ovfAcc_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign output_reg = result_q;
    assign sig_done   = (state_q == DONE);
    assign busy_o     = (state_q != IDLE);
`ifdef EXP_OVF_EN
    assign ovf_o      = ovf_q;
`else
    assign ovf_o      = 1'b0;
`endif

endmodule

// File: tb/tb_exp_power_unit.sv
// Scoreboard bench for exp_power_unit: expected results and completion cycles are queued
// at stimulus time and compared whenever sig_done fires.
module tb_exp_power_unit;

    logic        clk;
    logic        rst;
    logic        go_i;
    logic [7:0]  a_i;
    logic [7:0]  n_i;
    logic [15:0] output_reg;
    logic        sig_done;
    logic        busy_o;
    logic        ovf_o;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          doneCycle;
    } expect_t;

    expect_t sb[$];
    int      errors   = 0;
    int      checks   = 0;
    int      cycleCnt = 0;

    exp_power_unit #(.W_A(8), .W_N(8), .W_OUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .go_i       (go_i),
        .a_i        (a_i),
        .n_i        (n_i),
        .output_reg (output_reg),
        .sig_done   (sig_done),
        .busy_o     (busy_o),
        .ovf_o      (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cycleCnt);
        end
    endtask

    function automatic int bitLen(input int n);
        int k = 0;
        while ((n >> k) != 0) k++;
        return k;
    endfunction

    // Reference: plain repeated multiplication; overflow means the true power exceeds 16 bits.
    function automatic expect_t model(input int a, input int n);
        expect_t     e;
        logic [15:0] wrap = 16'd1;
        longint      trueVal = 1;
        bit          big = 1'b0;
        for (int i = 0; i < n; i++) begin
            wrap = 16'(wrap * 16'(a));
            if (!big) begin
                trueVal = trueVal * a;
                if (trueVal > 65535) big = 1'b1;
            end
        end
`ifdef EXP_OVF_EN
        e.res = big ? 16'hFFFF : wrap;
        e.ovf = big;
`else
        e.res = wrap;
        e.ovf = 1'b0;
`endif
        e.doneCycle = 0;
        return e;
    endfunction

    task automatic applyStimulus(input int a, input int n);
        expect_t e;
        @(negedge clk);
        a_i  = 8'(a);
        n_i  = 8'(n);
        go_i = 1'b1;
        e = model(a, n);
        e.doneCycle = cycleCnt + bitLen(n) + 2;
        sb.push_back(e);
        @(negedge clk);
        go_i = 1'b0;
        a_i  = 8'($urandom);
        n_i  = 8'($urandom);
    endtask

    task automatic waitDrain(input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        checkOutput("drainTimeout", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && sig_done) begin
            if (sb.size() == 0) begin
                checkOutput("spuriousDone", 32'(sig_done), 32'd0);
            end else begin
                expect_t e;
                e = sb.pop_front();
                checkOutput("result", 32'(output_reg), 32'(e.res));
                checkOutput("ovf", 32'(ovf_o), 32'(e.ovf));
                checkOutput("latency", 32'(cycleCnt), 32'(e.doneCycle));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        rst  = 1'b1;
        go_i = 1'b0;
        a_i  = '0;
        n_i  = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstResult", 32'(output_reg), 32'd0);
        checkOutput("rstDone", 32'(sig_done), 32'd0);
        checkOutput("rstBusy", 32'(busy_o), 32'd0);
        checkOutput("rstOvf", 32'(ovf_o), 32'd0);
        rst = 1'b0;

        applyStimulus(3, 5);
        waitDrain(100);
        applyStimulus(0, 0);
        waitDrain(100);
        applyStimulus(0, 200);
        waitDrain(100);
        applyStimulus(2, 15);
        waitDrain(100);
        applyStimulus(2, 16);
        waitDrain(100);
        applyStimulus(1, 255);
        waitDrain(100);
        applyStimulus(7, 0);
        waitDrain(100);
        for (int t = 0; t < 8; t++) begin
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 40)));
            waitDrain(100);
        end

        // Second go during RUN must be ignored; busy must hold through the DONE cycle.
        applyStimulus(255, 255);
        for (int i = 0; i <= 9; i++) begin
            checkOutput("busyRun", 32'(busy_o), 32'd1);
            if (i < 9) begin
                go_i = (i == 2);
                @(negedge clk);
            end
        end
        go_i = 1'b0;
        waitDrain(100);
        checkOutput("busyIdle", 32'(busy_o), 32'd0);

        // Abort mid-operation: nothing is queued, so any sig_done is reported as spurious.
        @(negedge clk);
        a_i  = 8'd5;
        n_i  = 8'd7;
        go_i = 1'b1;
        @(negedge clk);
        go_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        go_i = 1'b1;
        @(negedge clk);
        checkOutput("abortBusy", 32'(busy_o), 32'd0);
        checkOutput("abortResult", 32'(output_reg), 32'd0);
        checkOutput("abortDone", 32'(sig_done), 32'd0);
        rst  = 1'b0;
        go_i = 1'b0;
        repeat (20) @(negedge clk);
        applyStimulus(5, 3);
        waitDrain(100);

        // go_i held high: accepts every 5 cycles at c0+1, c0+6, c0+11.
        @(negedge clk);
        c0   = cycleCnt;
        a_i  = 8'd3;
        n_i  = 8'd2;
        go_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            expect_t e;
            e = model(3, 2);
            e.doneCycle = c0 + 4 + 5 * j;
            sb.push_back(e);
        end
        repeat (13) @(posedge clk);
        @(negedge clk);
        go_i = 1'b0;
        waitDrain(100);
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exp_power_unit.md
EXP_POWER_UNIT -- requirements
Module: exp_power_unit

Interface
REQ-001 SHALL have parameter W_A, default 8: width of base operand a_i.
REQ-002 SHALL have parameter W_N, default 8: width of exponent operand n_i.
REQ-003 SHALL have parameter W_OUT, default 16: width of result; W_OUT >= W_A is required.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 go_i  input  1  start request, sampled only in IDLE.
REQ-007 a_i  input  W_A  base, unsigned.
REQ-008 n_i  input  W_N  exponent, unsigned.
REQ-009 output_reg  output  W_OUT  registered result a^n; holds until the next completion.
REQ-010 sig_done  output  1  one-cycle completion strobe.
REQ-011 busy_o  output  1  high in every non-IDLE state.
REQ-012 ovf_o  output  1  overflow flag for the last result; updated with output_reg.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, RUN, DONE.
REQ-014 IDLE with go_i=1 at edge E0 SHALL: load base<=zero-extended a_i, exp<=n_i, acc<=1, ovf_acc<=0; go to RUN.
REQ-015 RUN with exp!=0 SHALL, per edge: if exp[0] then acc<=acc*base; base<=base*base; exp<=exp>>1. All products are truncated to W_OUT bits.
REQ-016 RUN with exp==0 SHALL go to DONE and load output_reg<=acc and ovf_o<=ovf_acc on that edge.
REQ-017 DONE SHALL assert sig_done for exactly one cycle and return to IDLE on the next edge.
REQ-018 Latency: with k = bit length of n (k=0 for n=0), sig_done SHALL be high in the cycle following edge E(k+1).
REQ-019 go_i SHALL be ignored in RUN and DONE; no queuing.
REQ-020 a_i and n_i SHALL be sampled only at E0; later changes SHALL NOT affect the result.
REQ-021 0^0 SHALL equal 1; 0^n for n>0 SHALL equal 0; x^0 SHALL equal 1.
REQ-022 Back-to-back: go_i held high SHALL start a new operation on the edge after DONE returns to IDLE.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE; output_reg=0, sig_done=0, busy_o=0, ovf_o=0; internal acc, base, exp and ovf_acc are cleared.
REQ-024 rst asserted mid-operation SHALL abort the operation with no sig_done pulse and no update of output_reg.
REQ-025 rst SHALL take priority over go_i in the same cycle.

Configuration
REQ-026 Macro EXP_OVF_EN defined: ovf_acc SHALL become set when the acc product exceeds W_OUT bits, or when the base square exceeds W_OUT bits while (exp>>1)!=0.
REQ-027 Macro EXP_OVF_EN defined: when ovf_acc=1 at the DONE transition, output_reg SHALL load all-ones and ovf_o SHALL load 1.
REQ-028 Macro EXP_OVF_EN undefined: results SHALL wrap modulo 2^W_OUT, ovf_o SHALL be constant 0, and no overflow logic SHALL be synthesised.

Verification (defaults W_A=8, W_N=8, W_OUT=16)
REQ-029 a=3, n=5, go at E0 -> sig_done high after E4; output_reg=243 (0x00F3); ovf_o=0.
REQ-030 a=0, n=0 -> sig_done after E1, output_reg=1; a=0, n=200 -> output_reg=0, ovf_o=0.
REQ-031 a=2, n=15 -> 32768 (0x8000), ovf_o=0 (the last base square overflow is not flagged); a=2, n=16 -> with EXP_OVF_EN: 0xFFFF and ovf_o=1; without: 0x0000 and ovf_o=0.
REQ-032 a=255, n=255 started, go_i pulsed again during RUN -> second go ignored; exactly one sig_done; busy_o high from E1 through the DONE cycle.
REQ-033 Start a=5, n=7, assert rst two cycles later -> no sig_done; output_reg=0; busy_o=0. A following go with a=5, n=3 -> output_reg=125.
REQ-034 go_i held high continuously with a=3, n=2 -> sig_done pulses repeat every 5 cycles (k=2: E0 accept, RUN through E3, DONE, IDLE accept); output_reg=9 each time.
